// File: rtl/jam_perm_search_if.sv
// Handshake bundle between the assignment solver and its harness (start control, cost-table lookup, results).
// BestPerm is only present when JAM_BEST_PERM_EN is defined.
interface jam_perm_search_if #(
    parameter int N    = 8,
    parameter int CW   = 7,
    parameter int CNTW = 16
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int SW = CW + IW;

    logic            Start;
    logic            Busy;
    logic [IW-1:0]   W;
    logic [IW-1:0]   J;
    logic [CW-1:0]   Cost;
    logic [CNTW-1:0] MatchCount;
    logic [SW-1:0]   MinCost;
    logic            Valid;
`ifdef JAM_BEST_PERM_EN
    logic [N*IW-1:0] BestPerm;

    modport master (output Start, Cost, input Busy, W, J, MatchCount, MinCost, Valid, BestPerm);
    modport slave  (input Start, Cost, output Busy, W, J, MatchCount, MinCost, Valid, BestPerm);
`else
    modport master (output Start, Cost, input Busy, W, J, MatchCount, MinCost, Valid);
    modport slave  (input Start, Cost, output Busy, W, J, MatchCount, MinCost, Valid);
`endif
endinterface

// File: rtl/jam_perm_search.sv
// Exhaustive N-worker/N-job assignment solver: walks all N! permutations in lexicographic order,
// tracking the minimum total cost and its multiplicity. Optional BestPerm output via JAM_BEST_PERM_EN.
module jam_perm_search #(
    parameter int N    = 8,
    parameter int CW   = 7,
    parameter int CNTW = 16
) (
    input  logic CLK,
    input  logic RST,
    jam_perm_search_if.slave bus
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int SW = CW + IW;

    typedef enum logic [2:0] {IDLE, ISSUE, ACC, NEXT, DONE} state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   perm_q [N];
    logic [IW-1:0]   perm_d [N];
    logic [IW-1:0]   k_q, k_d, w_q, w_d, j_q, j_d, piv_q, piv_d;
    logic            phase_q, phase_d;
    logic [SW-1:0]   sum_q, sum_d, min_q, min_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
`ifdef JAM_BEST_PERM_EN
    logic [N*IW-1:0] best_q, best_d;
`endif

    logic [SW-1:0]   total;
    logic            pivFound;
    logic [IW-1:0]   pivIdx, swapIdx, kNext, revSrc;

    assign total = sum_q + SW'(bus.Cost);
    assign kNext = k_q + 1'b1;

    // Pivot is the rightmost ascent; no ascent means the permutation is fully descending (last one).
    always_comb begin
        pivFound = 1'b0;
        pivIdx   = '0;
        swapIdx  = '0;
        for (int i = 0; i < N - 1; i++) begin
            if (perm_q[i] < perm_q[i+1]) begin
                pivFound = 1'b1;
                pivIdx   = IW'(i);
            end
        end
        for (int j = 0; j < N; j++) begin
            if (j > int'(pivIdx) && perm_q[j] > perm_q[pivIdx]) begin
                swapIdx = IW'(j);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        perm_d  = perm_q;
        k_d     = k_q;
        w_d     = w_q;
        j_d     = j_q;
        piv_d   = piv_q;
        phase_d = phase_q;
        sum_d   = sum_q;
        min_d   = min_q;
        cnt_d   = cnt_q;
        revSrc  = '0;
`ifdef JAM_BEST_PERM_EN
        best_d  = best_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.Start) begin
                    for (int i = 0; i < N; i++) perm_d[i] = IW'(i);
                    cnt_d   = '0;
                    min_d   = '1;
                    sum_d   = '0;
                    k_d     = '0;
                    w_d     = '0;
                    j_d     = '0;
`ifdef JAM_BEST_PERM_EN
                    best_d  = '0;
`endif
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                // Cost arrives one cycle after its W/J, so cycle 0 only clears the running sum.
                sum_d = (k_q == '0) ? '0 : total;
                if (k_q == IW'(N - 1)) begin
                    state_d = ACC;
                end else begin
                    k_d = kNext;
                    w_d = kNext;
                    j_d = perm_q[kNext];
                end
            end
            ACC: begin
                if (total < min_q) begin
                    min_d = total;
                    cnt_d = CNTW'(1);
`ifdef JAM_BEST_PERM_EN
                    for (int w = 0; w < N; w++) best_d[w*IW +: IW] = perm_q[w];
`endif
                end else if (total == min_q && cnt_q != '1) begin
                    cnt_d = cnt_q + 1'b1;
                end
                phase_d = 1'b0;
                state_d = pivFound ? NEXT : DONE;
            end
            NEXT: begin
                if (!phase_q) begin
                    perm_d[pivIdx]  = perm_q[swapIdx];
                    perm_d[swapIdx] = perm_q[pivIdx];
                    piv_d   = pivIdx;
                    phase_d = 1'b1;
                end else begin
                    for (int t = 0; t < N; t++) begin
                        if (t > int'(piv_q)) begin
                            revSrc    = IW'(N + int'(piv_q) - t);
                            perm_d[t] = perm_q[revSrc];
                        end
                    end
                    // Position 0 is never inside the reversed suffix, so P[0] is already final.
                    k_d     = '0;
                    w_d     = '0;
                    j_d     = perm_q[0];
                    state_d = ISSUE;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            for (int i = 0; i < N; i++) perm_q[i] <= IW'(i);
            k_q     <= '0;
            w_q     <= '0;
            j_q     <= '0;
            piv_q   <= '0;
            phase_q <= 1'b0;
            sum_q   <= '0;
            min_q   <= '1;
            cnt_q   <= '0;
`ifdef JAM_BEST_PERM_EN
            best_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            perm_q  <= perm_d;
            k_q     <= k_d;
            w_q     <= w_d;
            j_q     <= j_d;
            piv_q   <= piv_d;
            phase_q <= phase_d;
            sum_q   <= sum_d;
            min_q   <= min_d;
            cnt_q   <= cnt_d;
`ifdef JAM_BEST_PERM_EN
            best_q  <= best_d;
`endif
        end
    end

    assign bus.Busy       = (state_q == ISSUE) || (state_q == ACC) || (state_q == NEXT);
    assign bus.Valid      = (state_q == DONE);
    assign bus.W          = w_q;
    assign bus.J          = j_q;
    assign bus.MatchCount = cnt_q;
    assign bus.MinCost    = min_q;
`ifdef JAM_BEST_PERM_EN
    assign bus.BestPerm   = best_q;
`endif
endmodule

// File: tb/tb_jam_perm_search.sv
// Directed bench for jam_perm_search: N=3, N=4 and N=6 solvers, each beside a registered cost ROM.
module tb_jam_perm_search;
    logic CLK = 1'b0;
    logic RST;
    int   mode;
    int   checks = 0;
    int   errors = 0;

    always #5 CLK = ~CLK;

    jam_perm_search_if #(.N(3), .CW(7), .CNTW(16)) bus3 ();
    jam_perm_search_if #(.N(4), .CW(7), .CNTW(16)) bus4 ();
    jam_perm_search_if #(.N(6), .CW(7), .CNTW(16)) bus6 ();

    jam_perm_search #(.N(3), .CW(7), .CNTW(16)) dut3 (.CLK(CLK), .RST(RST), .bus(bus3.slave));
    jam_perm_search #(.N(4), .CW(7), .CNTW(16)) dut4 (.CLK(CLK), .RST(RST), .bus(bus4.slave));
    jam_perm_search #(.N(6), .CW(7), .CNTW(16)) dut6 (.CLK(CLK), .RST(RST), .bus(bus6.slave));

    // Cost tables: 0 all ones, 1 diagonal free, 2 w*3+j+1, 3 cyclic shift cheap, 4 cost=job index
    function automatic int costOf(input int m, input int n, input int w, input int j);
        case (m)
            0: return 1;
            1: return (w == j) ? 0 : 10;
            2: return w * 3 + j + 1;
            3: return (j == (w + 1) % n) ? 1 : 50;
            default: return j;
        endcase
    endfunction

    always @(posedge CLK) begin
        bus3.Cost <= 7'(costOf(mode, 3, int'(bus3.W), int'(bus3.J)));
        bus4.Cost <= 7'(costOf(mode, 4, int'(bus4.W), int'(bus4.J)));
        bus6.Cost <= 7'(costOf(mode, 6, int'(bus6.W), int'(bus6.J)));
    end

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic getValid(input int sel);
        case (sel)
            3: return bus3.Valid;
            4: return bus4.Valid;
            default: return bus6.Valid;
        endcase
    endfunction

    function automatic logic getBusy(input int sel);
        case (sel)
            3: return bus3.Busy;
            4: return bus4.Busy;
            default: return bus6.Busy;
        endcase
    endfunction

    function automatic logic [63:0] getMin(input int sel);
        case (sel)
            3: return 64'(bus3.MinCost);
            4: return 64'(bus4.MinCost);
            default: return 64'(bus6.MinCost);
        endcase
    endfunction

    function automatic logic [63:0] getCnt(input int sel);
        case (sel)
            3: return 64'(bus3.MatchCount);
            4: return 64'(bus4.MatchCount);
            default: return 64'(bus6.MatchCount);
        endcase
    endfunction

    task automatic setStart(input int sel, input logic v);
        case (sel)
            3: bus3.Start = v;
            4: bus4.Start = v;
            default: bus6.Start = v;
        endcase
    endtask

    task automatic applyStimulus(input int sel, input int m);
        mode = m;
        @(negedge CLK);
        setStart(sel, 1'b1);
        @(negedge CLK);
        setStart(sel, 1'b0);
    endtask

    task automatic waitValid(input string tag, input int sel, input int limit);
        bit hit = 1'b0;
        for (int c = 0; c < limit && !hit; c++) begin
            if (getValid(sel)) hit = 1'b1;
            else @(negedge CLK);
        end
        checkOutput({tag, "_valid"}, 64'(hit), 64'd1);
        if (hit) checkOutput({tag, "_busyAtValid"}, 64'(getBusy(sel)), 64'd0);
    endtask

    task automatic runSearch(input string tag, input int sel, input int m, input int limit,
                             input logic [63:0] expMin, input logic [63:0] expCnt);
        applyStimulus(sel, m);
        checkOutput({tag, "_busy"}, 64'(getBusy(sel)), 64'd1);
        waitValid(tag, sel, limit);
        checkOutput({tag, "_min"}, getMin(sel), expMin);
        checkOutput({tag, "_cnt"}, getCnt(sel), expCnt);
    endtask

    initial begin
        RST = 1'b1;
        mode = 0;
        bus3.Start = 1'b0;
        bus4.Start = 1'b0;
        bus6.Start = 1'b0;
        repeat (3) @(negedge CLK);
        RST = 1'b0;

        checkOutput("rst_busy", 64'(bus6.Busy), 64'd0);
        checkOutput("rst_valid", 64'(bus6.Valid), 64'd0);
        checkOutput("rst_w", 64'(bus6.W), 64'd0);
        checkOutput("rst_j", 64'(bus6.J), 64'd0);
        checkOutput("rst_cnt", 64'(bus6.MatchCount), 64'd0);
        checkOutput("rst_min", 64'(bus6.MinCost), 64'd1023);
`ifdef JAM_BEST_PERM_EN
        checkOutput("rst_best", 64'(bus6.BestPerm), 64'd0);
`endif

        runSearch("n3_rowcol", 3, 2, 63, 64'd15, 64'd6);
        @(negedge CLK);
        checkOutput("n3_validPulse", 64'(bus3.Valid), 64'd0);
        checkOutput("n3_holdMin", 64'(bus3.MinCost), 64'd15);

        runSearch("n4_shift", 4, 3, 200, 64'd4, 64'd1);
`ifdef JAM_BEST_PERM_EN
        checkOutput("n4_shift_best", 64'(bus4.BestPerm), 64'h39);
`endif
        runSearch("n4_ones", 4, 0, 200, 64'd4, 64'd24);
`ifdef JAM_BEST_PERM_EN
        checkOutput("n4_ones_best", 64'(bus4.BestPerm), 64'd228);
`endif
        runSearch("n4_jobidx", 4, 4, 200, 64'd6, 64'd24);

        runSearch("n6_ones", 6, 0, 12000, 64'd6, 64'd720);
        runSearch("n6_diag", 6, 1, 12000, 64'd0, 64'd1);
`ifdef JAM_BEST_PERM_EN
        checkOutput("n6_diag_best", 64'(bus6.BestPerm), 64'd181896);
`endif

        // Start re-pulsed mid-search must not restart or queue a second run
        applyStimulus(4, 3);
        repeat (30) @(negedge CLK);
        bus4.Start = 1'b1;
        @(negedge CLK);
        bus4.Start = 1'b0;
        waitValid("n4_restart", 4, 200);
        checkOutput("n4_restart_min", getMin(4), 64'd4);
        checkOutput("n4_restart_cnt", getCnt(4), 64'd1);
        repeat (5) @(negedge CLK);
        checkOutput("n4_restart_idle", 64'(bus4.Busy), 64'd0);

        // Reset in the middle of a long search, then a fresh run
        applyStimulus(6, 0);
        repeat (100) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        checkOutput("midrst_busy", 64'(bus6.Busy), 64'd0);
        checkOutput("midrst_w", 64'(bus6.W), 64'd0);
        checkOutput("midrst_j", 64'(bus6.J), 64'd0);
        checkOutput("midrst_cnt", 64'(bus6.MatchCount), 64'd0);
        checkOutput("midrst_min", 64'(bus6.MinCost), 64'd1023);
        runSearch("n6_afterRst", 6, 1, 12000, 64'd0, 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
